// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and Datamem: queues stores and retires them when the port is free.
// Optional macro STORE_FWD_EN: load hits are forwarded from the youngest matching entry instead of stalling.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_write_exmem,
  input  logic                     mem_read_exmem,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     stall,
  output logic                     dm_we,
  output logic                     dm_mem_read,
  output logic [ADDR_W-1:0]        dm_address,
  output logic [DATA_W-1:0]        dm_data_in,
  input  logic [DATA_W-1:0]        dm_data_out,
  output logic [DATA_W-1:0]        load_data,
  output logic                     load_valid,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] ent;
  logic [PW-1:0]      head, tail, idx;
  logic [CW-1:0]      count;
  logic               ld, st, hit, ld_mem, ld_fwd, ld_stall, full, drain;
  logic [DATA_W-1:0]  fwd_data;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent[idx].vld && ent[idx].addr == address) begin
        hit      = 1'b1;
        fwd_data = ent[idx].data;
      end
    end
  end

  // A simultaneous read+write request is treated as a load; the store is dropped.
  assign ld     = mem_read_exmem;
  assign st     = mem_write_exmem & ~mem_read_exmem;
  assign ld_mem = ld & ~hit;
  assign full   = (count == CW'(DEPTH));
`ifdef STORE_FWD_EN
  assign ld_fwd   = ld & hit;
  assign ld_stall = 1'b0;
`else
  assign ld_fwd   = 1'b0;
  assign ld_stall = ld & hit;
`endif

  // Stores only steal a drain slot when the buffer is full; otherwise they just queue.
  assign drain = (count != '0) & ~ld_mem & (~st | full);

  always_comb begin
    stall       = 1'b0;
    dm_we       = 1'b0;
    dm_mem_read = 1'b0;
    dm_address  = '0;
    dm_data_in  = '0;
    load_data   = '0;
    load_valid  = 1'b0;
    if (rst) begin
      stall = ld_stall;
      if (ld_mem) begin
        dm_mem_read = 1'b1;
        dm_address  = address;
        load_data   = dm_data_out;
        load_valid  = 1'b1;
      end else if (drain) begin
        dm_we      = 1'b1;
        dm_address = ent[head].addr;
        dm_data_in = ent[head].data;
      end
      if (ld_fwd) begin
        load_data  = fwd_data;
        load_valid = 1'b1;
      end
    end
  end

  assign sb_count = count;
  assign sb_empty = (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (drain) begin
        ent[head].vld <= 1'b0;
        head          <= head + PW'(1);
      end
      // When full, head == tail: the push below overrides the pop's valid clear.
      if (st) begin
        ent[tail] <= '{vld: 1'b1, addr: address, data: data_in};
        tail      <= tail + PW'(1);
      end
      count <= count + CW'(st) - CW'(drain);
    end
  end
endmodule
